// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 7-bit Fibonacci LFSR pattern generator.
// Optional saturating error counter is built only when PRBS_CHECKER_ERR_COUNT_EN is defined.
module prbs_checker #(
    parameter int DATA_WIDTH = 7,
    parameter int TAP        = 3,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [DATA_WIDTH:1]   data_in,
    output logic                  locked,
    output logic                  error,
    output logic [ERR_W-1:0]      err_count,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                state_d, state_q;
    logic [DATA_WIDTH:1]   predict_d, predict_q;
    logic [3:0]            match_cnt_d, match_cnt_q;
    logic [3:0]            miss_cnt_d, miss_cnt_q;
    logic                  locked_d, locked_q;
    logic                  error_d, error_q;

    function automatic logic [DATA_WIDTH:1] next_word(input logic [DATA_WIDTH:1] s);
        return {s[DATA_WIDTH-1:1], s[TAP] ^ s[DATA_WIDTH]};
    endfunction

    always_comb begin
        state_d     = state_q;
        predict_d   = predict_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        error_d     = 1'b0;
        if (valid) begin
            case (state_q)
                SEARCH: begin
                    if (data_in != '0) begin
                        predict_d   = next_word(data_in);
                        match_cnt_d = '0;
                        state_d     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (data_in == '0) begin
                        state_d = SEARCH;
                    end else if (data_in == predict_q) begin
                        predict_d   = next_word(data_in);
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_d == 4'(LOCK_COUNT)) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        predict_d   = next_word(data_in);
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction advances on its own, so corrupt words never reseed it.
                    predict_d = next_word(predict_q);
                    if (data_in == predict_q) begin
                        miss_cnt_d = '0;
                    end else begin
                        error_d    = 1'b1;
                        miss_cnt_d = miss_cnt_q + 4'd1;
                        if (miss_cnt_d == 4'(LOSS_COUNT)) begin
                            state_d = SEARCH;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SEARCH;
            predict_q   <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            predict_q   <= predict_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            error_q     <= error_d;
        end
    end

`ifdef PRBS_CHECKER_ERR_COUNT_EN
    logic [ERR_W-1:0] err_count_d, err_count_q;

    // Saturate at all-ones so a long bad run never wraps back to a small count.
    always_comb begin
        err_count_d = err_count_q;
        if (error_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

    assign locked = locked_q;
    assign error  = error_q;
    assign state  = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed self-checking bench for prbs_checker; a second instance with ERR_W=2
// shares the same stream to observe counter saturation.
module tb_prbs_checker;

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

`ifdef PRBS_CHECKER_ERR_COUNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:1] dataIn;
    logic       locked, error;
    logic [7:0] errCount;
    logic [1:0] state;
    logic       lockedSat, errorSat;
    logic [1:0] errCountSat;
    logic [1:0] stateSat;

    int         checks   = 0;
    int         errors   = 0;
    int         errModel = 0;
    logic [7:1] cur;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .data_in   (dataIn),
        .locked    (locked),
        .error     (error),
        .err_count (errCount),
        .state     (state)
    );

    prbs_checker #(.ERR_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .data_in   (dataIn),
        .locked    (lockedSat),
        .error     (errorSat),
        .err_count (errCountSat),
        .state     (stateSat)
    );

    // Generator step: new bit = s[3] ^ s[7], shifted in at bit 1.
    function automatic logic [7:1] nxt(input logic [7:1] s);
        return {s[6:1], s[3] ^ s[7]};
    endfunction

    task automatic applyStimulus(input logic v, input logic [7:1] d);
        valid  = v;
        dataIn = d;
        @(posedge clk);
        #1;
    endtask

    task automatic sendGood();
        applyStimulus(1'b1, cur);
        cur = nxt(cur);
    endtask

    task automatic sendBad();
        applyStimulus(1'b1, cur ^ 7'h01);
        cur = nxt(cur);
    endtask

    task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] expState, input logic expError);
        int satVal;
        satVal = (errModel > 3) ? 3 : errModel;
        checkOne({tag, ".state"}, {6'd0, state}, {6'd0, expState});
        checkOne({tag, ".locked"}, {7'd0, locked}, {7'd0, expState == LOCKED});
        checkOne({tag, ".error"}, {7'd0, error}, {7'd0, expError});
        checkOne({tag, ".err_count"}, errCount, CntEn ? 8'(errModel) : 8'd0);
        checkOne({tag, ".err_count_sat"}, {6'd0, errCountSat}, CntEn ? 8'(satVal) : 8'd0);
    endtask

    initial begin
        rst    = 1'b0;
        valid  = 1'b0;
        dataIn = '0;

        // Reset held while valid data is offered.
        applyStimulus(1'b1, 7'h05);
        applyStimulus(1'b1, 7'h05);
        checkOutput("reset", SEARCH, 1'b0);
        rst = 1'b1;

        // Clean seed-1 stream with hand-computed words.
        applyStimulus(1'b1, 7'h01);
        checkOutput("seed_exit", VERIFY, 1'b0);
        applyStimulus(1'b1, 7'h02);
        applyStimulus(1'b1, 7'h04);
        applyStimulus(1'b1, 7'h09);
        checkOutput("three_matches", VERIFY, 1'b0);
        applyStimulus(1'b1, 7'h12);
        checkOutput("lock_point", LOCKED, 1'b0);
        applyStimulus(1'b1, 7'h24);
        applyStimulus(1'b1, 7'h49);
        checkOutput("locked_clean", LOCKED, 1'b0);
        cur = 7'h13;

        // Single corrupted word, then flywheel match.
        sendBad();
        errModel++;
        checkOutput("single_miss", LOCKED, 1'b1);
        sendGood();
        checkOutput("flywheel_match", LOCKED, 1'b0);

        // Three consecutive misses drop lock on the third.
        sendBad();
        errModel++;
        checkOutput("miss1", LOCKED, 1'b1);
        sendBad();
        errModel++;
        checkOutput("miss2", LOCKED, 1'b1);
        sendBad();
        errModel++;
        checkOutput("miss3_unlock", SEARCH, 1'b1);
        applyStimulus(1'b0, 7'h00);
        checkOutput("idle_after_loss", SEARCH, 1'b0);

        // Relock: exit sample plus four matches.
        for (int i = 0; i < 4; i++) sendGood();
        checkOutput("relock_pending", VERIFY, 1'b0);
        sendGood();
        checkOutput("relocked", LOCKED, 1'b0);

        // Reset while locked with valid high.
        rst = 1'b0;
        applyStimulus(1'b1, cur);
        errModel = 0;
        checkOutput("reset_mid_lock", SEARCH, 1'b0);
        rst = 1'b1;

        // Zero words: ignored in SEARCH, abort VERIFY.
        applyStimulus(1'b1, 7'h00);
        checkOutput("zero_in_search", SEARCH, 1'b0);
        sendGood();
        checkOutput("verify_again", VERIFY, 1'b0);
        applyStimulus(1'b1, 7'h00);
        checkOutput("zero_in_verify", SEARCH, 1'b0);
        sendGood();
        checkOutput("verify_reseeded", VERIFY, 1'b0);

        // Alternate valid; gaps carry junk data that must be ignored.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 7'h55);
            checkOutput("gap", VERIFY, 1'b0);
            sendGood();
            if (i == 3) checkOutput("gapped_three", VERIFY, 1'b0);
        end
        checkOutput("gapped_lock", LOCKED, 1'b0);

        // Five misses interleaved with matches: lock held, narrow counter saturates.
        for (int i = 0; i < 5; i++) begin
            sendBad();
            errModel++;
            checkOutput("sat_miss", LOCKED, 1'b1);
            sendGood();
            checkOutput("sat_match", LOCKED, 1'b0);
        end

        // Valid gaps do not break a miss run.
        sendBad();
        errModel++;
        applyStimulus(1'b0, 7'h00);
        checkOutput("gap_miss1", LOCKED, 1'b0);
        sendBad();
        errModel++;
        applyStimulus(1'b0, 7'h00);
        checkOutput("gap_miss2", LOCKED, 1'b0);
        sendBad();
        errModel++;
        checkOutput("gap_miss3_unlock", SEARCH, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
